// File: rtl/uart_fifo_top_pkg.sv
// ---------------------------------------------------------------------------
// uart_fifo_top_pkg
// Shared definitions for the FIFO-buffered 8N1 UART:
//   - uart_state_e : state encoding used by both the RX and TX frame FSMs
//   - *_DEF        : default values for the top-level parameters
// No ports (package).
// ---------------------------------------------------------------------------
package uart_fifo_top_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int DBIT_DEF    = 8;    // data bits per frame
    localparam int SB_TICK_DEF = 16;   // oversampling ticks in the stop bit
    localparam int DVSR_DEF    = 163;  // clocks per oversampling tick
    localparam int FIFO_W_DEF  = 2;    // FIFO address width (depth 2**FIFO_W)

endpackage : uart_fifo_top_pkg

// File: rtl/uart_fifo.sv
// ---------------------------------------------------------------------------
// uart_fifo
// Register-array FIFO with wrap-around pointers and registered full/empty
// flags. Read data is first-word-fall-through (r_data = mem[r_ptr]).
// Ports:
//   clk    in          clock, rising edge
//   rst_n  in          asynchronous reset, active-low
//   rd     in          pop the head word (ignored while empty)
//   wr     in          push w_data (dropped while full unless rd pops too)
//   w_data in  DATA_W  word to push
//   empty  out         FIFO empty
//   full   out         FIFO full
//   r_data out DATA_W  head word
// ---------------------------------------------------------------------------
module uart_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd,
    input  logic              wr,
    input  logic [DATA_W-1:0] w_data,
    output logic              empty,
    output logic              full,
    output logic [DATA_W-1:0] r_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [ADDR_W-1:0] w_ptr_r;
    logic [ADDR_W-1:0] r_ptr_r;
    logic [ADDR_W-1:0] w_ptr_inc_s;
    logic [ADDR_W-1:0] r_ptr_inc_s;
    logic              empty_r;
    logic              full_r;
    logic              wr_en_s;
    logic              rd_en_s;

    // A write while full still succeeds when the same cycle pops a word:
    // the slot being vacated is the one being written.
    assign wr_en_s     = wr & (~full_r | rd);
    assign rd_en_s     = rd & ~empty_r;
    assign w_ptr_inc_s = w_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign r_ptr_inc_s = r_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};

    // Storage array; cleared on reset so the head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_r[w_ptr_r] <= w_data;
        end
    end

    // Pointer and flag update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr_r <= {ADDR_W{1'b0}};
            r_ptr_r <= {ADDR_W{1'b0}};
            empty_r <= 1'b1;
            full_r  <= 1'b0;
        end else begin
            case ({wr_en_s, rd_en_s})
                2'b10: begin
                    w_ptr_r <= w_ptr_inc_s;
                    empty_r <= 1'b0;
                    full_r  <= (w_ptr_inc_s == r_ptr_r);
                end
                2'b01: begin
                    r_ptr_r <= r_ptr_inc_s;
                    full_r  <= 1'b0;
                    empty_r <= (r_ptr_inc_s == w_ptr_r);
                end
                2'b11: begin
                    // Occupancy unchanged, so the flags hold.
                    w_ptr_r <= w_ptr_inc_s;
                    r_ptr_r <= r_ptr_inc_s;
                end
                default: begin
                    w_ptr_r <= w_ptr_r;
                    r_ptr_r <= r_ptr_r;
                end
            endcase
        end
    end

    assign empty  = empty_r;
    assign full   = full_r;
    assign r_data = mem_r[r_ptr_r];

endmodule : uart_fifo

// File: rtl/uart_fifo_top.sv
// ---------------------------------------------------------------------------
// uart_fifo_top
// Full-duplex 8N1 UART: free-running baud-tick generator, 16x oversampling
// receiver, transmitter, and a FIFO on each direction toward the host.
// Ports:
//   i_clk      in        system clock, rising edge
//   i_reset    in        asynchronous reset, active-low
//   i_rd_uart  in        pop RX FIFO head
//   i_wr_uart  in        push i_w_data into TX FIFO
//   i_rx       in        serial input, idles high
//   i_w_data   in  DBIT  word to transmit
//   o_tx_full  out       TX FIFO full
//   o_rx_empty out       RX FIFO empty
//   o_tx       out       serial output, idles high (registered)
//   o_r_data   out DBIT  RX FIFO head (first-word-fall-through)
// ---------------------------------------------------------------------------
module uart_fifo_top
    import uart_fifo_top_pkg::*;
#(
    parameter int DBIT    = DBIT_DEF,
    parameter int SB_TICK = SB_TICK_DEF,
    parameter int DVSR    = DVSR_DEF,
    parameter int FIFO_W  = FIFO_W_DEF
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_rd_uart,
    input  logic            i_wr_uart,
    input  logic            i_rx,
    input  logic [DBIT-1:0] i_w_data,
    output logic            o_tx_full,
    output logic            o_rx_empty,
    output logic            o_tx,
    output logic [DBIT-1:0] o_r_data
);

    localparam int          CW       = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int          NW       = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DVSR - 1);
    localparam logic [NW-1:0] N_LAST   = NW'(DBIT - 1);
    localparam logic [5:0]  SB_LAST  = 6'(SB_TICK - 1);
    localparam logic [5:0]  MID_TICK = 6'd7;
    localparam logic [5:0]  BIT_LAST = 6'd15;

    // ---------------- baud generator ----------------
    logic [CW-1:0] baud_cnt_r;
    logic          tick_s;

    assign tick_s = (baud_cnt_r == CNT_LAST);

    // Free-running divide-by-DVSR counter.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            baud_cnt_r <= {CW{1'b0}};
        end else if (tick_s) begin
            baud_cnt_r <= {CW{1'b0}};
        end else begin
            baud_cnt_r <= baud_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // ---------------- receiver ----------------
    uart_state_e     rx_state_r, rx_state_n;
    logic [5:0]      rx_s_r, rx_s_n;
    logic [NW-1:0]   rx_n_r, rx_n_n;
    logic [DBIT-1:0] rx_b_r, rx_b_n;
    logic            rx_meta_r, rx_sync_r;
    logic            rx_done_s;
    logic            rx_full_s;

    // Two-flop synchronizer on the asynchronous serial input.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= i_rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // RX FSM state register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rx_state_r <= ST_IDLE;
            rx_s_r     <= 6'd0;
            rx_n_r     <= {NW{1'b0}};
            rx_b_r     <= {DBIT{1'b0}};
        end else begin
            rx_state_r <= rx_state_n;
            rx_s_r     <= rx_s_n;
            rx_n_r     <= rx_n_n;
            rx_b_r     <= rx_b_n;
        end
    end

    // RX next-state: sample mid start bit, then every 16 ticks.
    always_comb begin
        rx_state_n = rx_state_r;
        rx_s_n     = rx_s_r;
        rx_n_n     = rx_n_r;
        rx_b_n     = rx_b_r;
        rx_done_s  = 1'b0;
        case (rx_state_r)
            ST_IDLE: begin
                if (!rx_sync_r) begin
                    rx_state_n = ST_START;
                    rx_s_n     = 6'd0;
                end else begin
                    rx_state_n = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    if (rx_s_r == MID_TICK) begin
                        // Line back high at mid start bit: treat as a glitch.
                        if (!rx_sync_r) begin
                            rx_state_n = ST_DATA;
                            rx_s_n     = 6'd0;
                            rx_n_n     = {NW{1'b0}};
                        end else begin
                            rx_state_n = ST_IDLE;
                        end
                    end else begin
                        rx_s_n = rx_s_r + 6'd1;
                    end
                end else begin
                    rx_s_n = rx_s_r;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    if (rx_s_r == BIT_LAST) begin
                        rx_s_n = 6'd0;
                        rx_b_n = {rx_sync_r, rx_b_r[DBIT-1:1]};
                        if (rx_n_r == N_LAST) begin
                            rx_state_n = ST_STOP;
                        end else begin
                            rx_n_n = rx_n_r + {{(NW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        rx_s_n = rx_s_r + 6'd1;
                    end
                end else begin
                    rx_s_n = rx_s_r;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    if (rx_s_r == SB_LAST) begin
                        rx_state_n = ST_IDLE;
                        rx_done_s  = 1'b1;
                    end else begin
                        rx_s_n = rx_s_r + 6'd1;
                    end
                end else begin
                    rx_s_n = rx_s_r;
                end
            end
            default: begin
                rx_state_n = ST_IDLE;
            end
        endcase
    end

    // A word arriving while the RX FIFO is full is dropped unless the host
    // pops in the same cycle; the FIFO applies the same rule, this just
    // keeps the intent visible here.
    uart_fifo #(.DATA_W(DBIT), .ADDR_W(FIFO_W)) u_rx_fifo (
        .clk    (i_clk),
        .rst_n  (i_reset),
        .rd     (i_rd_uart),
        .wr     (rx_done_s & (~rx_full_s | i_rd_uart)),
        .w_data (rx_b_r),
        .empty  (o_rx_empty),
        .full   (rx_full_s),
        .r_data (o_r_data)
    );

    // ---------------- transmitter ----------------
    uart_state_e     tx_state_r, tx_state_n;
    logic [5:0]      tx_s_r, tx_s_n;
    logic [NW-1:0]   tx_n_r, tx_n_n;
    logic [DBIT-1:0] tx_b_r, tx_b_n;
    logic            tx_r, tx_n;
    logic            tx_pop_s;
    logic            tx_empty_s;
    logic [DBIT-1:0] tx_head_s;

    uart_fifo #(.DATA_W(DBIT), .ADDR_W(FIFO_W)) u_tx_fifo (
        .clk    (i_clk),
        .rst_n  (i_reset),
        .rd     (tx_pop_s),
        .wr     (i_wr_uart),
        .w_data (i_w_data),
        .empty  (tx_empty_s),
        .full   (o_tx_full),
        .r_data (tx_head_s)
    );

    // TX FSM state register and registered serial output.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            tx_state_r <= ST_IDLE;
            tx_s_r     <= 6'd0;
            tx_n_r     <= {NW{1'b0}};
            tx_b_r     <= {DBIT{1'b0}};
            tx_r       <= 1'b1;
        end else begin
            tx_state_r <= tx_state_n;
            tx_s_r     <= tx_s_n;
            tx_n_r     <= tx_n_n;
            tx_b_r     <= tx_b_n;
            tx_r       <= tx_n;
        end
    end

    // TX next-state: each bit held for 16 ticks (SB_TICK for stop).
    always_comb begin
        tx_state_n = tx_state_r;
        tx_s_n     = tx_s_r;
        tx_n_n     = tx_n_r;
        tx_b_n     = tx_b_r;
        tx_n       = 1'b1;
        tx_pop_s   = 1'b0;
        case (tx_state_r)
            ST_IDLE: begin
                tx_n = 1'b1;
                if (!tx_empty_s) begin
                    tx_b_n     = tx_head_s;
                    tx_pop_s   = 1'b1;
                    tx_state_n = ST_START;
                    tx_s_n     = 6'd0;
                end else begin
                    tx_state_n = ST_IDLE;
                end
            end
            ST_START: begin
                tx_n = 1'b0;
                if (tick_s) begin
                    if (tx_s_r == BIT_LAST) begin
                        tx_state_n = ST_DATA;
                        tx_s_n     = 6'd0;
                        tx_n_n     = {NW{1'b0}};
                    end else begin
                        tx_s_n = tx_s_r + 6'd1;
                    end
                end else begin
                    tx_s_n = tx_s_r;
                end
            end
            ST_DATA: begin
                tx_n = tx_b_r[0];
                if (tick_s) begin
                    if (tx_s_r == BIT_LAST) begin
                        tx_s_n = 6'd0;
                        tx_b_n = {1'b0, tx_b_r[DBIT-1:1]};
                        if (tx_n_r == N_LAST) begin
                            tx_state_n = ST_STOP;
                        end else begin
                            tx_n_n = tx_n_r + {{(NW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        tx_s_n = tx_s_r + 6'd1;
                    end
                end else begin
                    tx_s_n = tx_s_r;
                end
            end
            ST_STOP: begin
                tx_n = 1'b1;
                if (tick_s) begin
                    if (tx_s_r == SB_LAST) begin
                        tx_state_n = ST_IDLE;
                    end else begin
                        tx_s_n = tx_s_r + 6'd1;
                    end
                end else begin
                    tx_s_n = tx_s_r;
                end
            end
            default: begin
                tx_state_n = ST_IDLE;
                tx_n       = 1'b1;
            end
        endcase
    end

    assign o_tx = tx_r;

endmodule : uart_fifo_top

// File: tb/tb_uart_fifo_top.sv
// ---------------------------------------------------------------------------
// tb_uart_fifo_top
// Directed self-checking bench for uart_fifo_top. A short divider keeps
// frames brief; one serial bit lasts BIT = 16*DVSR clocks. Stimulus is
// driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_uart_fifo_top;

    localparam int DVSR = 4;
    localparam int BIT  = 16 * DVSR;
    localparam int TMO  = 30 * BIT;

    logic       clk;
    logic       rst_n;
    logic       rd_uart;
    logic       wr_uart;
    logic       rx_drv;
    logic       loop;
    logic [7:0] w_data;
    logic       tx_full;
    logic       rx_empty;
    logic       tx;
    logic [7:0] r_data;
    logic       rx_line;

    int checks   = 0;
    int failures = 0;

    assign rx_line = loop ? tx : rx_drv;

    uart_fifo_top #(
        .DBIT    (8),
        .SB_TICK (16),
        .DVSR    (DVSR),
        .FIFO_W  (2)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_rd_uart  (rd_uart),
        .i_wr_uart  (wr_uart),
        .i_rx       (rx_line),
        .i_w_data   (w_data),
        .o_tx_full  (tx_full),
        .o_rx_empty (rx_empty),
        .o_tx       (tx),
        .o_r_data   (r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one 8N1 frame on the bench-side RX line.
    task automatic send_byte(input logic [7:0] d);
        @(negedge clk) rx_drv = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx_drv = d[k];
            repeat (BIT) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic pop();
        @(negedge clk) rd_uart = 1'b1;
        @(negedge clk) rd_uart = 1'b0;
    endtask

    task automatic wait_rx(output logic found);
        found = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (!rx_empty) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Find a start edge on o_tx and sample each bit in its middle.
    task automatic cap_frame(output logic [7:0] d, output logic start_ok,
                             output logic stop_ok, output logic seen);
        seen     = 1'b0;
        start_ok = 1'b0;
        stop_ok  = 1'b0;
        d        = 8'h00;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (tx == 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        if (seen) begin
            repeat (BIT / 2) @(negedge clk);
            start_ok = (tx == 1'b0);
            for (int k = 0; k < 8; k++) begin
                repeat (BIT) @(negedge clk);
                d[k] = tx;
            end
            repeat (BIT) @(negedge clk);
            stop_ok = tx;
        end
    endtask

    // Count low samples of o_tx over a window.
    task automatic count_tx_low(input int cycles, output int lows);
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx == 1'b0) lows++;
        end
    endtask

    logic [7:0] cap_d;
    logic       cap_start, cap_stop, cap_seen, found;
    int         lows;
    logic [7:0] words [6];

    initial begin
        rst_n   = 1'b0;
        rd_uart = 1'b0;
        wr_uart = 1'b0;
        rx_drv  = 1'b1;
        loop    = 1'b0;
        w_data  = 8'h00;
        words   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        repeat (4) @(negedge clk);

        // Reset state
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_rx_empty", {31'd0, rx_empty}, 32'd1);
        chk("rst_tx_full", {31'd0, tx_full}, 32'd0);
        chk("rst_r_data", {24'd0, r_data}, 32'h00);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single received word
        send_byte(8'hAA);
        chk("rx1_empty", {31'd0, rx_empty}, 32'd0);
        chk("rx1_data", {24'd0, r_data}, 32'hAA);
        pop();
        chk("rx1_empty_after_pop", {31'd0, rx_empty}, 32'd1);

        // Overflow: five words, fourth fills the FIFO, fifth is dropped
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        chk("ovf_empty", {31'd0, rx_empty}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ovf_pop%0d", i), {24'd0, r_data}, 32'(i));
            pop();
        end
        chk("ovf_empty_after", {31'd0, rx_empty}, 32'd1);
        // Head slot still holds 0x01 (r_ptr wrapped back to slot 1)
        pop();
        chk("pop_empty_data", {24'd0, r_data}, 32'h01);
        chk("pop_empty_flag", {31'd0, rx_empty}, 32'd1);

        // Single transmitted word
        fork
            begin
                @(negedge clk) begin wr_uart = 1'b1; w_data = 8'h55; end
                @(negedge clk) wr_uart = 1'b0;
            end
            cap_frame(cap_d, cap_start, cap_stop, cap_seen);
        join
        chk("tx55_seen", {31'd0, cap_seen}, 32'd1);
        chk("tx55_start", {31'd0, cap_start}, 32'd1);
        chk("tx55_data", {24'd0, cap_d}, 32'h55);
        chk("tx55_stop", {31'd0, cap_stop}, 32'd1);
        count_tx_low(2 * BIT, lows);
        chk("tx55_idle", 32'(lows), 32'd0);

        // Six back-to-back writes: one in flight, four queued, one dropped
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk) begin wr_uart = 1'b1; w_data = words[i]; end
                end
                @(negedge clk) wr_uart = 1'b0;
                chk("tx6_full", {31'd0, tx_full}, 32'd1);
            end
            cap_frame(cap_d, cap_start, cap_stop, cap_seen);
        join
        chk("tx6_w0", {24'd0, cap_d}, 32'h11);
        found = 1'b0;
        for (int i = 0; i < 2 * BIT; i++) begin
            @(negedge clk);
            if (!tx_full) begin
                found = 1'b1;
                break;
            end
        end
        chk("tx6_full_drop", {31'd0, found}, 32'd1);
        for (int i = 1; i < 5; i++) begin
            cap_frame(cap_d, cap_start, cap_stop, cap_seen);
            chk($sformatf("tx6_w%0d", i), {24'd0, cap_d}, {24'd0, words[i]});
        end
        count_tx_low(12 * BIT, lows);
        chk("tx6_sixth_dropped", 32'(lows), 32'd0);

        // Loopback
        @(negedge clk) loop = 1'b1;
        @(negedge clk) begin wr_uart = 1'b1; w_data = 8'h3C; end
        @(negedge clk) w_data = 8'hC3;
        @(negedge clk) wr_uart = 1'b0;
        wait_rx(found);
        chk("loop_found0", {31'd0, found}, 32'd1);
        chk("loop_w0", {24'd0, r_data}, 32'h3C);
        pop();
        wait_rx(found);
        chk("loop_found1", {31'd0, found}, 32'd1);
        chk("loop_w1", {24'd0, r_data}, 32'hC3);
        pop();
        chk("loop_empty", {31'd0, rx_empty}, 32'd1);
        repeat (2 * BIT) @(negedge clk);
        loop = 1'b0;

        // One-tick glitch on the RX line is rejected
        @(negedge clk) rx_drv = 1'b0;
        repeat (DVSR) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        chk("glitch_empty", {31'd0, rx_empty}, 32'd1);

        // Reset in the middle of an RX frame and a TX frame
        @(negedge clk) begin wr_uart = 1'b1; w_data = 8'h00; end
        @(negedge clk) begin wr_uart = 1'b0; rx_drv = 1'b0; end
        repeat (4 * BIT) @(negedge clk);
        rst_n  = 1'b0;
        rx_drv = 1'b1;
        @(negedge clk);
        chk("mrst_tx", {31'd0, tx}, 32'd1);
        chk("mrst_rx_empty", {31'd0, rx_empty}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        count_tx_low(12 * BIT, lows);
        chk("mrst_tx_idle", 32'(lows), 32'd0);
        chk("mrst_no_partial", {31'd0, rx_empty}, 32'd1);
        send_byte(8'h96);
        chk("mrst_clean_empty", {31'd0, rx_empty}, 32'd0);
        chk("mrst_clean_data", {24'd0, r_data}, 32'h96);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_fifo_top
